// File: rtl/div_reservation_station.sv
// Reservation station feeding the integer divider: holds dispatched divides,
// wakes missing operands from the CDB, issues ready entries through a single
// valid/ready output register and frees each entry on its own CDB result.

package div_pkg;
    typedef struct packed {
        logic is_signed;
        logic want_rem;
    } div_decode_t;
endpackage

module div_reservation_station
    import div_pkg::*;
#(
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned RS_DEPTH    = 4,
    parameter int unsigned RS_OFFSET   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
    input  logic [31:0]            op1_value,
    input  logic [31:0]            op2_value,
    input  logic                   op1_present,
    input  logic                   op2_present,
    input  logic [RS_ID_WIDTH-1:0] op1_tag,
    input  logic [RS_ID_WIDTH-1:0] op2_tag,
    input  div_decode_t            control,
    input  logic [4:0]             result_reg_addr_in,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [4:0]             issue_result_reg_addr,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output div_decode_t            issue_control
);

    localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_FREE,
        ST_WAITING,
        ST_READY,
        ST_ISSUED
    } ent_state_e;

    function automatic logic [RS_ID_WIDTH-1:0] ent_id(input int unsigned k);
        return RS_ID_WIDTH'(RS_OFFSET + k);
    endfunction

    // Entry storage
    ent_state_e             state_q   [RS_DEPTH];
    ent_state_e             state_d   [RS_DEPTH];
    logic [31:0]            op1_q     [RS_DEPTH];
    logic [31:0]            op1_d     [RS_DEPTH];
    logic [31:0]            op2_q     [RS_DEPTH];
    logic [31:0]            op2_d     [RS_DEPTH];
    logic                   op1_ok_q  [RS_DEPTH];
    logic                   op1_ok_d  [RS_DEPTH];
    logic                   op2_ok_q  [RS_DEPTH];
    logic                   op2_ok_d  [RS_DEPTH];
    logic [RS_ID_WIDTH-1:0] op1_tag_q [RS_DEPTH];
    logic [RS_ID_WIDTH-1:0] op1_tag_d [RS_DEPTH];
    logic [RS_ID_WIDTH-1:0] op2_tag_q [RS_DEPTH];
    logic [RS_ID_WIDTH-1:0] op2_tag_d [RS_DEPTH];
    div_decode_t            ctrl_q    [RS_DEPTH];
    div_decode_t            ctrl_d    [RS_DEPTH];
    logic [4:0]             rd_q      [RS_DEPTH];
    logic [4:0]             rd_d      [RS_DEPTH];

    // Issue output register
    logic                   iss_valid_q, iss_valid_d;
    logic [RS_ID_WIDTH-1:0] iss_rs_id_q, iss_rs_id_d;
    logic [4:0]             iss_rd_q,    iss_rd_d;
    logic [31:0]            iss_op1_q,   iss_op1_d;
    logic [31:0]            iss_op2_q,   iss_op2_d;
    div_decode_t            iss_ctrl_q,  iss_ctrl_d;

    // Selection / handshake terms
    logic             any_free, any_ready, disp_fire, iss_load;
    logic [IDX_W-1:0] free_idx, rdy_idx;
    logic [31:0]      disp_op1, disp_op2;
    logic             disp_op1_ok, disp_op2_ok;

    // Lowest FREE / lowest READY selection from registered state, plus dispatch bypass
    always_comb begin
        any_free  = 1'b0;
        any_ready = 1'b0;
        free_idx  = '0;
        rdy_idx   = '0;
        for (int unsigned k = 0; k < RS_DEPTH; k++) begin
            if (!any_free && state_q[k] == ST_FREE) begin
                any_free = 1'b1;
                free_idx = IDX_W'(k);
            end
            if (!any_ready && state_q[k] == ST_READY) begin
                any_ready = 1'b1;
                rdy_idx   = IDX_W'(k);
            end
        end
        disp_fire = dispatch_valid && any_free;
        iss_load  = (!iss_valid_q || issue_ready) && any_ready;

        disp_op1    = op1_value;
        disp_op1_ok = op1_present;
        if (!op1_present && cdb_valid && cdb_rs_id == op1_tag) begin
            disp_op1    = cdb_result;
            disp_op1_ok = 1'b1;
        end
        disp_op2    = op2_value;
        disp_op2_ok = op2_present;
        if (!op2_present && cdb_valid && cdb_rs_id == op2_tag) begin
            disp_op2    = cdb_result;
            disp_op2_ok = 1'b1;
        end
    end

    // State register: entries and issue stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < RS_DEPTH; k++) begin
                state_q[k]   <= ST_FREE;
                op1_q[k]     <= '0;
                op2_q[k]     <= '0;
                op1_ok_q[k]  <= 1'b0;
                op2_ok_q[k]  <= 1'b0;
                op1_tag_q[k] <= '0;
                op2_tag_q[k] <= '0;
                ctrl_q[k]    <= '0;
                rd_q[k]      <= '0;
            end
            iss_valid_q <= 1'b0;
            iss_rs_id_q <= '0;
            iss_rd_q    <= '0;
            iss_op1_q   <= '0;
            iss_op2_q   <= '0;
            iss_ctrl_q  <= '0;
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            op1_ok_q    <= op1_ok_d;
            op2_ok_q    <= op2_ok_d;
            op1_tag_q   <= op1_tag_d;
            op2_tag_q   <= op2_tag_d;
            ctrl_q      <= ctrl_d;
            rd_q        <= rd_d;
            iss_valid_q <= iss_valid_d;
            iss_rs_id_q <= iss_rs_id_d;
            iss_rd_q    <= iss_rd_d;
            iss_op1_q   <= iss_op1_d;
            iss_op2_q   <= iss_op2_d;
            iss_ctrl_q  <= iss_ctrl_d;
        end
    end

    // Next-state: dispatch, CDB wakeup, issue and CDB free per entry; issue register load
    always_comb begin
        for (int unsigned k = 0; k < RS_DEPTH; k++) begin
            state_d[k]   = state_q[k];
            op1_d[k]     = op1_q[k];
            op2_d[k]     = op2_q[k];
            op1_ok_d[k]  = op1_ok_q[k];
            op2_ok_d[k]  = op2_ok_q[k];
            op1_tag_d[k] = op1_tag_q[k];
            op2_tag_d[k] = op2_tag_q[k];
            ctrl_d[k]    = ctrl_q[k];
            rd_d[k]      = rd_q[k];

            case (state_q[k])
                ST_FREE: begin
                    if (disp_fire && free_idx == IDX_W'(k)) begin
                        op1_d[k]     = disp_op1;
                        op2_d[k]     = disp_op2;
                        op1_ok_d[k]  = disp_op1_ok;
                        op2_ok_d[k]  = disp_op2_ok;
                        op1_tag_d[k] = op1_tag;
                        op2_tag_d[k] = op2_tag;
                        ctrl_d[k]    = control;
                        rd_d[k]      = result_reg_addr_in;
                        state_d[k]   = (disp_op1_ok && disp_op2_ok) ? ST_READY : ST_WAITING;
                    end
                end
                ST_WAITING: begin
                    if (!op1_ok_q[k] && cdb_valid && cdb_rs_id == op1_tag_q[k]) begin
                        op1_d[k]    = cdb_result;
                        op1_ok_d[k] = 1'b1;
                    end
                    if (!op2_ok_q[k] && cdb_valid && cdb_rs_id == op2_tag_q[k]) begin
                        op2_d[k]    = cdb_result;
                        op2_ok_d[k] = 1'b1;
                    end
                    if (op1_ok_d[k] && op2_ok_d[k]) begin
                        state_d[k] = ST_READY;
                    end
                end
                ST_READY: begin
                    if (iss_load && rdy_idx == IDX_W'(k)) begin
                        state_d[k] = ST_ISSUED;
                    end
                end
                ST_ISSUED: begin
                    if (cdb_valid && cdb_rs_id == ent_id(k)) begin
                        state_d[k] = ST_FREE;
                    end
                end
                default: state_d[k] = ST_FREE;
            endcase
        end

        iss_valid_d = iss_valid_q;
        iss_rs_id_d = iss_rs_id_q;
        iss_rd_d    = iss_rd_q;
        iss_op1_d   = iss_op1_q;
        iss_op2_d   = iss_op2_q;
        iss_ctrl_d  = iss_ctrl_q;
        if (iss_load) begin
            iss_valid_d = 1'b1;
            iss_rs_id_d = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(rdy_idx);
            iss_rd_d    = rd_q[rdy_idx];
            iss_op1_d   = op1_q[rdy_idx];
            iss_op2_d   = op2_q[rdy_idx];
            iss_ctrl_d  = ctrl_q[rdy_idx];
        end else if (issue_ready) begin
            iss_valid_d = 1'b0;
        end
    end

    // Outputs: dispatch availability from registered state, issue stage straight from flops
    always_comb begin
        dispatch_ready        = any_free;
        dispatch_rs_id        = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(free_idx);
        issue_valid           = iss_valid_q;
        issue_rs_id           = iss_rs_id_q;
        issue_result_reg_addr = iss_rd_q;
        issue_op1             = iss_op1_q;
        issue_op2             = iss_op2_q;
        issue_control         = iss_ctrl_q;
    end

endmodule

// File: tb/tb_div_reservation_station.sv
// Directed bench for div_reservation_station: latency, wakeup, bypass,
// backpressure, full/free interplay and asynchronous reset.

module tb_div_reservation_station;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [4:0]  dispatch_rs_id;
    logic [31:0] op1_value, op2_value;
    logic        op1_present, op2_present;
    logic [4:0]  op1_tag, op2_tag;
    div_decode_t control;
    logic [4:0]  result_reg_addr_in;
    logic        cdb_valid;
    logic [4:0]  cdb_rs_id;
    logic [31:0] cdb_result;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rs_id;
    logic [4:0]  issue_result_reg_addr;
    logic [31:0] issue_op1, issue_op2;
    div_decode_t issue_control;

    int n_cmp = 0;
    int n_bad = 0;

    div_reservation_station #(
        .RS_ID_WIDTH(5),
        .RS_DEPTH   (4),
        .RS_OFFSET  (8)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .dispatch_valid       (dispatch_valid),
        .dispatch_ready       (dispatch_ready),
        .dispatch_rs_id       (dispatch_rs_id),
        .op1_value            (op1_value),
        .op2_value            (op2_value),
        .op1_present          (op1_present),
        .op2_present          (op2_present),
        .op1_tag              (op1_tag),
        .op2_tag              (op2_tag),
        .control              (control),
        .result_reg_addr_in   (result_reg_addr_in),
        .cdb_valid            (cdb_valid),
        .cdb_rs_id            (cdb_rs_id),
        .cdb_result           (cdb_result),
        .issue_valid          (issue_valid),
        .issue_ready          (issue_ready),
        .issue_rs_id          (issue_rs_id),
        .issue_result_reg_addr(issue_result_reg_addr),
        .issue_op1            (issue_op1),
        .issue_op2            (issue_op2),
        .issue_control        (issue_control)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cdb(input logic [4:0] id, input logic [31:0] val);
        cdb_valid  = 1'b1;
        cdb_rs_id  = id;
        cdb_result = val;
    endtask

    task automatic cdb_off();
        cdb_valid = 1'b0;
    endtask

    task automatic disp(input logic [31:0] v1, input logic p1, input logic [4:0] t1,
                        input logic [31:0] v2, input logic p2, input logic [4:0] t2,
                        input logic [4:0] rd);
        op1_value          = v1;
        op1_present        = p1;
        op1_tag            = t1;
        op2_value          = v2;
        op2_present        = p2;
        op2_tag            = t2;
        result_reg_addr_in = rd;
        dispatch_valid     = 1'b1;
        tick();
        dispatch_valid     = 1'b0;
        op1_present        = 1'b0;
        op2_present        = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        dispatch_valid     = 1'b0;
        op1_value          = '0;
        op2_value          = '0;
        op1_present        = 1'b0;
        op2_present        = 1'b0;
        op1_tag            = '0;
        op2_tag            = '0;
        control            = '0;
        result_reg_addr_in = '0;
        cdb_valid          = 1'b0;
        cdb_rs_id          = '0;
        cdb_result         = '0;
        issue_ready        = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_disp_ready",  32'(dispatch_ready), 1);
        chk("rst_disp_rs_id",  32'(dispatch_rs_id), 8);
        chk("rst_issue_rs_id", 32'(issue_rs_id), 0);
        chk("rst_issue_op1",   issue_op1, 0);

        // Both operands present: issue one edge after dispatch, then free via CDB
        control = '{is_signed: 1'b1, want_rem: 1'b0};
        disp(100, 1'b1, 5'd0, 7, 1'b1, 5'd0, 5'd3);
        control = '0;
        chk("t1_no_issue_yet", 32'(issue_valid), 0);
        chk("t1_next_rs_id",   32'(dispatch_rs_id), 9);
        tick();
        chk("t1_issue_valid",  32'(issue_valid), 1);
        chk("t1_issue_rs_id",  32'(issue_rs_id), 8);
        chk("t1_issue_op1",    issue_op1, 100);
        chk("t1_issue_op2",    issue_op2, 7);
        chk("t1_issue_rd",     32'(issue_result_reg_addr), 3);
        chk("t1_issue_ctrl",   32'(issue_control), 2);
        tick();
        chk("t1_valid_clear",  32'(issue_valid), 0);
        chk("t1_still_issued", 32'(dispatch_rs_id), 9);
        cdb(8, 0);
        tick();
        cdb_off();
        chk("t1_freed_rs_id",  32'(dispatch_rs_id), 8);

        // op2 waits on tag 3; op1 present with a matching tag must not be overwritten
        disp(20, 1'b1, 5'd3, 0, 1'b0, 5'd3, 5'd4);
        tick();
        chk("t2_waiting",      32'(issue_valid), 0);
        cdb(3, 5);
        tick();
        cdb_off();
        chk("t2_woke_no_iss",  32'(issue_valid), 0);
        tick();
        chk("t2_issue_valid",  32'(issue_valid), 1);
        chk("t2_issue_rs_id",  32'(issue_rs_id), 8);
        chk("t2_op1_kept",     issue_op1, 20);
        chk("t2_op2_woken",    issue_op2, 5);
        tick();
        cdb(8, 0);
        tick();
        cdb_off();

        // Dispatch bypass: op1 tag 2 broadcast in the dispatch cycle
        cdb(2, 42);
        disp(0, 1'b0, 5'd2, 6, 1'b1, 5'd0, 5'd7);
        cdb_off();
        chk("t3_bypass_lat",   32'(issue_valid), 0);
        tick();
        chk("t3_issue_valid",  32'(issue_valid), 1);
        chk("t3_issue_op1",    issue_op1, 42);
        chk("t3_issue_op2",    issue_op2, 6);
        tick();
        cdb(8, 0);
        tick();
        cdb_off();

        // Both operands on tag 4; an unrelated tag is ignored, then both wake together
        disp(0, 1'b0, 5'd4, 0, 1'b0, 5'd4, 5'd1);
        cdb(5, 77);
        tick();
        cdb_off();
        tick();
        chk("t4_stray_tag",    32'(issue_valid), 0);
        cdb(4, 9);
        tick();
        cdb_off();
        tick();
        chk("t4_issue_valid",  32'(issue_valid), 1);
        chk("t4_op1",          issue_op1, 9);
        chk("t4_op2",          issue_op2, 9);
        tick();
        cdb(8, 0);
        tick();
        cdb_off();

        // Fill all entries under backpressure, payload must hold
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(32'(200 + k), 1'b1, 5'd0, 32'(k + 1), 1'b1, 5'd0, 5'(10 + k));
        end
        chk("t5_full",         32'(dispatch_ready), 0);
        chk("t5_valid",        32'(issue_valid), 1);
        op1_value      = 999;
        op1_present    = 1'b1;
        op2_present    = 1'b1;
        dispatch_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t5_hold_rs_id_%0d", i), 32'(issue_rs_id), 8);
            chk($sformatf("t5_hold_op1_%0d", i),   issue_op1, 200);
        end
        dispatch_valid = 1'b0;
        op1_present    = 1'b0;
        op2_present    = 1'b0;
        chk("t5_still_full",   32'(dispatch_ready), 0);
        issue_ready = 1'b1;
        tick();
        chk("t5_b2b_v9",       32'(issue_valid), 1);
        chk("t5_b2b_rs9",      32'(issue_rs_id), 9);
        chk("t5_b2b_op9",      issue_op1, 201);
        tick();
        chk("t5_b2b_v10",      32'(issue_valid), 1);
        chk("t5_b2b_rs10",     32'(issue_rs_id), 10);
        chk("t5_b2b_op10",     issue_op1, 202);
        tick();
        chk("t5_b2b_v11",      32'(issue_valid), 1);
        chk("t5_b2b_rs11",     32'(issue_rs_id), 11);
        chk("t5_b2b_op2_11",   issue_op2, 4);
        tick();
        chk("t5_drained",      32'(issue_valid), 0);
        chk("t5_all_issued",   32'(dispatch_ready), 0);

        // Free rs_id 10 while dispatch is requested: accepted only the following cycle
        op1_value          = 50;
        op1_present        = 1'b1;
        op2_value          = 5;
        op2_present        = 1'b1;
        result_reg_addr_in = 5'd9;
        dispatch_valid     = 1'b1;
        cdb(10, 0);
        tick();
        cdb_off();
        chk("t6_freed_ready",  32'(dispatch_ready), 1);
        chk("t6_freed_rs_id",  32'(dispatch_rs_id), 10);
        tick();
        dispatch_valid = 1'b0;
        op1_present    = 1'b0;
        op2_present    = 1'b0;
        chk("t6_refull",       32'(dispatch_ready), 0);
        tick();
        chk("t6_issue_valid",  32'(issue_valid), 1);
        chk("t6_issue_rs_id",  32'(issue_rs_id), 10);
        chk("t6_issue_op1",    issue_op1, 50);

        // Asynchronous reset in mid-cycle while issue_valid is high
        issue_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t7_async_valid",  32'(issue_valid), 0);
        chk("t7_async_ready",  32'(dispatch_ready), 1);
        chk("t7_async_rs_id",  32'(dispatch_rs_id), 8);
        chk("t7_async_iss_id", 32'(issue_rs_id), 0);
        @(negedge clk);
        rst = 1'b0;
        issue_ready = 1'b1;
        tick();
        chk("t7_discarded",    32'(issue_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
